ws2812_matrix_scanner: RTL

Downstream stage of the matrix framebuffer. On a start pulse it walks every pixel of the WIDTH x HEIGTH matrix, driving row/column to the framebuffer and sampling its combinational r/g/b read data. It serialises each pixel as 24 bits in WS2812 GRB order, MSB first, on a single data line. It then holds the line low for the latch/reset interval and signals frame completion.

---
 rtl/ws2812_matrix_scanner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ws2812_matrix_scanner.sv
// ws2812_matrix_scanner: walks a WIDTH x HEIGTH framebuffer and streams
// every pixel as 24 GRB bits, MSB first, on a WS2812 data line.
module ws2812_matrix_scanner #(
  parameter int WIDTH        = 32,
  parameter int HEIGTH       = 16,
  parameter int SERPENTINE   = 1,
  parameter int T_BIT        = 63,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int RESET_CYCLES = 3000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] row,
  output logic [7:0] column,
  input  logic [7:0] r_read,
  input  logic [7:0] g_read,
  input  logic [7:0] b_read,
  output logic       dout,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(T_BIT + 1);
  localparam int LW = $clog2(RESET_CYCLES + 2);
  localparam logic [7:0] COL_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] ROW_LAST = 8'(HEIGTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  state_t        state, state_nx;
  logic [23:0]   shreg;
  logic [4:0]    bit_idx;
  logic [CW-1:0] cyc;
  logic [LW-1:0] lcnt;
  logic [7:0]    row_nx, col_nx;
  logic          rev, row_end;
  logic          bit_end, last_bit, frame_end, lat_end, hi;

  assign bit_end  = cyc == CW'(T_BIT - 1);
  assign last_bit = bit_idx == 5'd0;
  // Address is already prefetched when bit 0 ends: back at (0,0) means last pixel.
  assign frame_end = bit_end && last_bit && row == 8'd0 && column == 8'd0;
  assign lat_end  = lcnt == LW'(RESET_CYCLES);
  assign hi = shreg[23] ? (cyc < CW'(T1H)) : (cyc < CW'(T0H));

  assign rev     = (SERPENTINE != 0) && row[0];
  assign row_end = rev ? (column == 8'd0) : (column == COL_LAST);

  always_comb begin
    row_nx = row;
    col_nx = column;
    if (!row_end) begin
      col_nx = rev ? column - 8'd1 : column + 8'd1;
    end else if (row == ROW_LAST) begin
      row_nx = 8'd0;
      col_nx = 8'd0;
    end else begin
      row_nx = row + 8'd1;
      col_nx = ((SERPENTINE != 0) && !row[0]) ? COL_LAST : 8'd0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD:  state_nx = SEND;
      SEND:  if (frame_end) state_nx = LATCH;
      LATCH: if (lat_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      cyc     <= '0;
      lcnt    <= '0;
      row     <= '0;
      column  <= '0;
      dout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= state_nx != IDLE;
      dout  <= (state == SEND) && hi;
      done  <= (state == LATCH) && (lcnt == LW'(RESET_CYCLES - 1));
      unique case (state)
        IDLE: begin
          cyc  <= '0;
          lcnt <= '0;
        end
        LOAD: begin
          shreg   <= {g_read, r_read, b_read};
          bit_idx <= 5'd23;
          cyc     <= '0;
        end
        SEND: begin
          lcnt <= '0;
          if (last_bit && cyc == '0) begin
            row    <= row_nx;
            column <= col_nx;
          end
          if (bit_end) begin
            cyc <= '0;
            if (last_bit) begin
              shreg   <= {g_read, r_read, b_read};
              bit_idx <= 5'd23;
            end else begin
              shreg   <= shreg << 1;
              bit_idx <= bit_idx - 5'd1;
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        LATCH: lcnt <= lcnt + LW'(1);
        default: ;
      endcase
    end
  end

endmodule
